uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_PERIOD_NS, default 60, system clock period in ns.
REQ-002 Parameter BIT_NS, default 104167, serial bit period in ns (9600 baud).
REQ-003 Derived constant CLKS_PER_BIT = BIT_NS / CLK_PERIOD_NS (integer division, 1736 at defaults); SHALL be >= 2, else elaboration error.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 data_in  input  7  parallel data word to send.
REQ-008 data_valid  input  1  request to send data_in.
REQ-009 data_ready  output  1  transmitter can accept a word this cycle.
REQ-010 transmit_bit  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  frame in progress (not IDLE).
REQ-012 done  output  1  one-cycle pulse at end of a frame's stop bit.

Function
REQ-013 Frame SHALL be 10 bits: start 0, data bits d0..d6 LSB first, parity, stop 1.
REQ-014 Parity bit SHALL be XOR of the 7 data bits, so data ones plus parity is even.
REQ-015 Each bit SHALL hold on transmit_bit for exactly CLKS_PER_BIT clock cycles; frame length = 10*CLKS_PER_BIT cycles.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; one bit-period cycle counter, 3-bit data index.
REQ-017 IDLE: transmit_bit=1, busy=0, data_ready=1.
REQ-018 Acceptance = data_valid & data_ready on a rising edge; data_in and its parity captured into an internal shift register at that edge.
REQ-019 On acceptance from IDLE, next state START; transmit_bit=0 visible the cycle after the accepting edge (latency 1).
REQ-020 START -> DATA after CLKS_PER_BIT cycles; DATA advances index each bit, -> PARITY after d6; PARITY -> STOP after one bit period.
REQ-021 data_ready SHALL be 0 in START, DATA, PARITY, and in STOP except its final cycle.
REQ-022 In the final cycle of STOP: done=1, data_ready=1.
REQ-023 Back-to-back: acceptance in final STOP cycle SHALL enter START directly, start bit immediately following stop bit, zero idle cycles.
REQ-024 No acceptance in final STOP cycle: -> IDLE.
REQ-025 data_valid while data_ready=0 SHALL be ignored, no buffering; changes to data_in after acceptance SHALL not affect the frame in flight.
REQ-026 done SHALL never be asserted for two consecutive cycles; busy SHALL stay 1 across a back-to-back transition.
REQ-027 Bit counter SHALL wrap to 0 at CLKS_PER_BIT-1 with no off-by-one; widths sized to hold CLKS_PER_BIT-1.

Reset
REQ-028 rst=1 SHALL immediately, without clock, force: state IDLE, transmit_bit=1, busy=0, done=0, data_ready=1, counters 0, shift register 0.
REQ-029 rst asserted mid-frame SHALL abandon the frame; no partial bits resume after rst deasserts.
REQ-030 data_valid during rst SHALL be ignored; first acceptance possible on first rising edge with rst=0.

Verification (CLK_PERIOD_NS=1, BIT_NS=4, CLKS_PER_BIT=4)
REQ-031 Send 7'h55 -> line 0,1,0,1,0,1,0,1,0,1 each 4 cycles (parity 0); done pulses in cycle 40 after acceptance; then IDLE.
REQ-032 Send 7'h07 -> data bits 1,1,1,0,0,0,0, parity 1, stop 1; busy high for exactly 40 cycles.
REQ-033 Send 7'h00, hold data_valid with 7'h7F at final STOP cycle -> frame 2 start bit directly follows frame 1 stop bit; frame 2 parity 1; busy never drops between frames.
REQ-034 Assert rst during d3 of 7'h2A -> transmit_bit=1, busy=0, data_ready=1 same cycle without clock edge; after release, line stays 1 until new acceptance.
REQ-035 Pulse data_valid with 7'h11 during frame of 7'h6C, change data_in mid-frame -> 7'h11 not sent, frame carries 7'h6C, parity 0.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 7-bit even-parity UART transmitter, one frame buffer, back-to-back capable
// Frame: start 0, d0..d6 LSB first, parity (XOR of data), stop 1; every bit held CLKS_PER_BIT cycles.
module uart_transmitter #(
  parameter int CLK_PERIOD_NS = 60,
  parameter int BIT_NS        = 104167
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       transmit_bit,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = BIT_NS / CLK_PERIOD_NS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          busy_q;
  logic          ready_q;
  logic          done_q;

  logic accept;
  logic bit_end;

  assign accept  = data_valid & ready_q;
  assign bit_end = (cnt_q == CNT_LAST);

  assign data_ready   = ready_q;
  assign transmit_bit = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // ready_q is only high in IDLE or the final STOP cycle, so accept covers both entry paths to START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (accept) begin
      state_q <= S_START;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= {^data_in, data_in};
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            if (idx_q == 3'd6) begin
              state_q <= S_PARITY;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Raise ready/done so they are visible exactly during the final stop cycle.
            if (cnt_q == CNT_PRE) begin
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter at CLKS_PER_BIT=4
// Expected per-cycle line/flag values are queued on acceptance and popped by a negedge monitor.
module tb_uart_transmitter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       transmit_bit;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic tx;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  uart_transmitter #(
    .CLK_PERIOD_NS(1),
    .BIT_NS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .transmit_bit(transmit_bit),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0b want=%0b t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: a frame is 10 bits, each held CPB cycles; ready/done only in the very last cycle.
  task automatic push_frame(input logic [6:0] d);
    logic [9:0] bits;
    exp_t e;
    bits[0] = 1'b0;
    for (int i = 0; i < 7; i++) bits[1+i] = d[i];
    bits[8] = ^d;
    bits[9] = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        e.tx    = bits[b];
        e.busy  = 1'b1;
        e.ready = (b == 9) && (c == CPB - 1);
        e.done  = e.ready;
        exp_q.push_back(e);
      end
    end
  endtask

  // Model of acceptance: the transmitter is ready exactly when no expected cycles remain.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (data_valid && exp_q.size() == 0) begin
      push_frame(data_in);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.tx = 1'b1; e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b0;
    end
    chk("transmit_bit", transmit_bit, e.tx);
    chk("busy", busy, e.busy);
    chk("data_ready", data_ready, e.ready);
    chk("done", done, e.done);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [6:0] d);
    @(negedge clk);
    #1;
    data_valid = 1'b1;
    data_in    = d;
    @(negedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = 7'($urandom);
  endtask

  initial begin
    wait_cycles(3);
    #1 rst = 1'b0;
    wait_cycles(2);

    send(7'h55);
    wait_cycles(45);
    send(7'h07);
    wait_cycles(45);

    // Back-to-back: valid held, data switches to 7F before the first frame ends.
    @(negedge clk);
    #1;
    data_valid = 1'b1;
    data_in    = 7'h00;
    @(negedge clk);
    #1 data_in = 7'h7F;
    wait_cycles(45);
    #1 data_valid = 1'b0;
    wait_cycles(45);

    // Asynchronous reset during d3 of 7'h2A, with data_valid high throughout reset.
    send(7'h2A);
    wait_cycles(17);
    #2;
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 7'h33;
    #1;
    chk("rst_async_tx", transmit_bit, 1'b1);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_ready", data_ready, 1'b1);
    chk("rst_async_done", done, 1'b0);
    exp_q.delete();
    wait_cycles(2);
    #1 data_valid = 1'b0;
    wait_cycles(3);
    #1 rst = 1'b0;
    wait_cycles(10);

    // Ignored request mid-frame with data_in churning.
    send(7'h6C);
    wait_cycles(8);
    send(7'h11);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 data_in = 7'($urandom);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      data_in    = 7'($urandom);
      data_valid = ($urandom_range(0, 5) == 0);
    end
    #1 data_valid = 1'b0;
    wait_cycles(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
